fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//   Shares the single write port of one FIFO between NUM_REQ requesters.
//   Fair round-robin arbitration; the winner holds the port for a burst of up
//   to MAX_BURST beats. Honours FIFO full, so FIFO overflow errors cannot occur.
//   Sits between the producer blocks and the FIFO write-side inputs
//   (wr_en_i, wdata_i, full_o). Single clock domain: the FIFO write clock.
// PARAMETERS
//   NUM_REQ    4   number of requesters (>=2)
//   WIDTH      8   data width; matches the FIFO WIDTH
//   MAX_BURST  4   maximum beats per grant (>=1)
//   IDX_W      2   requester index width, = clog2(NUM_REQ)
// PORTS
//   clk_i          in   1              clock: the FIFO write clock; all state on rising edge
//   rst_n_i        in   1              asynchronous, active-low reset
//   req_valid_i    in   NUM_REQ        per-requester data valid
//   req_data_i     in   NUM_REQ*WIDTH  packed data; requester k at [k*WIDTH +: WIDTH]
//   req_ready_o    out  NUM_REQ        per-requester accept; at most one bit high
//   fifo_full_i    in   1              FIFO full_o
//   fifo_wr_en_o   out  1              FIFO wr_en_i
//   fifo_wdata_o   out  WIDTH          FIFO wdata_i
//   grant_o        out  NUM_REQ        one-hot current owner; 0 when IDLE
//   grant_idx_o    out  IDX_W          index of the current/last owner
//   busy_o         out  1              1 when state is GRANT
// BEHAVIOUR
//   States:
//   - Two states: IDLE and GRANT. Registers: state, gnt_idx, last_idx, beat_cnt.
//   Reset (rst_n_i low, asynchronous):
//   - state=IDLE, gnt_idx=0, last_idx=NUM_REQ-1, beat_cnt=0.
//   - All outputs are 0: fifo_wr_en_o, fifo_wdata_o, req_ready_o, grant_o, grant_idx_o, busy_o.
//   - This holds mid-burst: the write is dropped in the same cycle.
//   - last_idx=NUM_REQ-1 gives requester 0 first priority.
//   IDLE:
//   - If any req_valid_i is high, pick the first valid index searching
//     last_idx+1, last_idx+2, ... with modulo NUM_REQ wrap.
//   - Register the winner into gnt_idx, clear beat_cnt, and go to GRANT.
//   - Arbitration latency is 1 cycle. No write happens in IDLE.
//   GRANT (g = gnt_idx):
//   - Only bit g of req_ready_o can be high: req_ready_o[g] = ~fifo_full_i.
//     This path is combinational.
//   - Beat: req_valid_i[g] & ~fifo_full_i. On a beat:
//     fifo_wr_en_o=1, fifo_wdata_o=req_data_i[g], beat_cnt++.
//   - fifo_wr_en_o and fifo_wdata_o are combinational from the registered grant.
//     fifo_wdata_o is 0 when there is no beat.
//   - Full stall: no beat and beat_cnt holds. Stays in GRANT as long as req_valid_i[g]=1.
//   Release (go to IDLE, last_idx<=g, beat_cnt<=0) when either:
//     a) a beat occurs with beat_cnt==MAX_BURST-1, or
//     b) req_valid_i[g]==0. This also applies when full is asserted in the same cycle.
//   - The IDLE cycle between grants is mandatory. It gives the synchronised full_o time to settle.
//   Width and arithmetic:
//   - beat_cnt is clog2(MAX_BURST)+1 bits wide and never wraps past MAX_BURST-1.
//   - The round-robin index wraps modulo NUM_REQ; NUM_REQ need not be a power of two.
//   Other rules:
//   - A requester that drops valid before its grant is not served. There is no request latching.
//   - Requester data is sampled only on a beat.
//   - Invariant: fifo_wr_en_o & fifo_full_i is never 1.
// STRUCTURE
//   - Shared package fifo_arb_pkg:
//     - state enum constants ST_IDLE=1'b0, ST_GRANT=1'b1
//     - clog2 function
//   - Sub-module rr_pick:
//     - Purely combinational.
//     - Inputs: req vector and last_idx. Outputs: any_o and win_idx_o.
//     - Implemented as a rotate, then a priority encode, then an un-rotate.
//   - Top level holds the FSM, the counters and the output muxing.
// TESTING
//   Bench defaults: NUM_REQ=4, WIDTH=8, MAX_BURST=4; free-running clock; FIFO model
//   DEPTH=16 with full_o. Scenarios:
//   1 Reset: rst_n_i=0 with random inputs -> all outputs 0; release with req 0..3 valid -> grant_o=4'b0001 first.
//   2 Round-robin: req0 and req2 always valid, data 8'hA0+n / 8'hC0+n, full=0
//     -> 4 writes A0..A3, 1 idle cycle, 4 writes C0..C3, idle, then A4..
//   3 Full stall: full=1 for 3 cycles after beat 2 of req1
//     -> wr_en=0 and ready=0 for those cycles; exactly 4 writes total; order preserved.
//   4 Early release: req3 drops valid after 2 beats -> IDLE next cycle; req0 (valid) granted; last_idx=3.
//   5 Reset mid-burst: rst_n_i low after beat 1 -> wr_en=0 in the same cycle, FIFO count +1 only;
//     after release req0 wins.
//   6 Single requester: only req1 valid for 20 cycles -> repeating 4-beat bursts with 1-cycle gaps.
//   Scoreboard: data order per requester in the FIFO; assert no write while full; ready is one-hot-or-zero.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
//   Shared definitions for the FIFO write-port arbiter.
//   - arb_state_e : arbiter FSM state encoding (IDLE / GRANT)
//   - clog2       : ceiling log2 used to size index and counter fields
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Searches req_i starting at
//   last_idx_i+1 and wrapping modulo NUM_REQ (NUM_REQ need not be a power
//   of two); returns the first requester found.
// Ports
//   req_i       in   NUM_REQ  request vector
//   last_idx_i  in   IDX_W    index of the previous winner
//   any_o       out  1        at least one request present
//   win_idx_o   out  IDX_W    winning index (valid when any_o=1)
// ---------------------------------------------------------------------------
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_idx_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   win_idx_o
);

  // (base + off) mod NUM_REQ; plain modulo keeps non-power-of-two sizes correct.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int unsigned     off);
    int unsigned sum;
    sum = (32'(base) + off) % NUM_REQ;
    return IDX_W'(sum);
  endfunction

  // Rotate so that bit 0 of rot is the requester right after the last winner.
  logic [NUM_REQ-1:0] rot;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    assign rot[gi] = req_i[wrap_add(last_idx_i, 32'(gi) + 32'd1)];
  end

  // Lowest set bit of the rotated vector = closest requester after last_idx.
  logic [IDX_W-1:0] pos;

  always_comb begin
    any_o = 1'b0;
    pos   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any_o = 1'b1;
        pos   = IDX_W'(k);
      end
    end
  end

  // Un-rotate back into absolute requester numbering.
  assign win_idx_o = wrap_add(last_idx_i, 32'(pos) + 32'd1);

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//   Shares one FIFO write port between NUM_REQ producers. Round-robin
//   arbitration in IDLE (one cycle), then the winner owns the port in GRANT
//   for up to MAX_BURST beats. A beat only happens when the FIFO is not
//   full, so the FIFO can never be overflowed through this port.
// Ports
//   clk_i         in   1              FIFO write clock
//   rst_n_i       in   1              asynchronous active-low reset
//   req_valid_i   in   NUM_REQ        per-requester data valid
//   req_data_i    in   NUM_REQ*WIDTH  requester k at [k*WIDTH +: WIDTH]
//   req_ready_o   out  NUM_REQ        accept strobe, at most one bit high
//   fifo_full_i   in   1              FIFO full flag
//   fifo_wr_en_o  out  1              FIFO write enable
//   fifo_wdata_o  out  WIDTH          FIFO write data (0 when no beat)
//   grant_o       out  NUM_REQ        one-hot owner in GRANT, 0 in IDLE
//   grant_idx_o   out  IDX_W          current / most recent owner
//   busy_o        out  1              high while in GRANT
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  parameter int IDX_W     = clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic                     fifo_full_i,
  output logic                     fifo_wr_en_o,
  output logic [WIDTH-1:0]         fifo_wdata_o,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic [IDX_W-1:0]         grant_idx_o,
  output logic                     busy_o
);

  localparam int                CNT_W     = clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0]  LAST_REQ  = IDX_W'(NUM_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0] last_idx_q, last_idx_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  // Unpack the flat data bus so the owner's word is a simple array select.
  logic [WIDTH-1:0] req_data_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_data_arr[gi] = req_data_i[gi*WIDTH +: WIDTH];
  end

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i      (req_valid_i),
    .last_idx_i (last_idx_q),
    .any_o      (pick_any),
    .win_idx_o  (pick_idx)
  );

  logic busy;
  logic own_valid;
  logic beat;

  assign busy      = (state_q == ST_GRANT);
  assign own_valid = req_valid_i[gnt_idx_q];
  // Full gates the beat directly, which is what keeps wr_en & full at zero.
  assign beat      = busy & own_valid & ~fifo_full_i;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
    assign grant_o[gi]     = busy & (gnt_idx_q == IDX_W'(gi));
    assign req_ready_o[gi] = busy & (gnt_idx_q == IDX_W'(gi)) & ~fifo_full_i;
  end

  // Everything below is combinational from registered state, so an
  // asynchronous reset drops an in-flight write in the same cycle.
  assign fifo_wr_en_o = beat;
  assign fifo_wdata_o = beat ? req_data_arr[gnt_idx_q] : '0;
  assign grant_idx_o  = gnt_idx_q;
  assign busy_o       = busy;

  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    last_idx_d = last_idx_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_idx_d  = pick_idx;
          beat_cnt_d = '0;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // Losing valid releases even while stalled on full; otherwise the
        // burst ends on its last beat.
        if (!own_valid || (beat && (beat_cnt_q == LAST_BEAT))) begin
          state_d    = ST_IDLE;
          last_idx_d = gnt_idx_q;
          beat_cnt_d = '0;
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      gnt_idx_q  <= '0;
      last_idx_q <= LAST_REQ;   // requester 0 gets first priority
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      last_idx_q <= last_idx_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, WIDTH=8, MAX_BURST=4)
//   with a 16-deep FIFO model on the write side.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int MB    = 4;
  localparam int IW    = 2;
  localparam int DEPTH = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           fifo_full;
  logic           wr_en;
  logic [W-1:0]   wdata;
  logic [N-1:0]   grant;
  logic [IW-1:0]  gidx;
  logic           busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ   (N),
    .WIDTH     (W),
    .MAX_BURST (MB),
    .IDX_W     (IW)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_ready_o  (req_ready),
    .fifo_full_i  (fifo_full),
    .fifo_wr_en_o (wr_en),
    .fifo_wdata_o (wdata),
    .grant_o      (grant),
    .grant_idx_o  (gidx),
    .busy_o       (busy)
  );

  // ---------------- bench state ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  bit          sb_en   = 1'b0;   // FIFO model + scoreboard active
  bit          freeze  = 1'b0;   // producers keep presenting the same word
  int unsigned pop_pct = 100;

  int seq[N];       // next word index each producer presents
  int pop_seq[N];   // next word index expected out of the FIFO per producer

  logic [W-1:0] fifo_q[$];

  typedef struct {
    int           cyc;
    logic [W-1:0] d;
  } wlog_t;
  wlog_t wlog[$];

  // Reference model: who owns the port, beats done in this burst,
  // round-robin pointer, and the index shown on grant_idx.
  int m_owner;
  int m_beats;
  int m_last;
  int m_shown;

  function automatic logic [W-1:0] base(input int k);
    return 8'(8'hA0 + 16 * k);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic drive(input logic rst, input logic [N-1:0] v, input logic ff);
    @(posedge clk);
    #1;
    rst_n     = rst;
    req_valid = v;
    fifo_full = ff | (sb_en && (fifo_q.size() >= DEPTH));
    for (int k = 0; k < N; k++) req_data[k*W +: W] = base(k) + W'(seq[k] % 16);
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);
    wlog.delete();
    fifo_q.delete();
    for (int k = 0; k < N; k++) begin
      seq[k]     = 0;
      pop_seq[k] = 0;
    end
  endtask

  // Runs at every falling edge: compare DUT against the model, then advance
  // the model, the FIFO model, the producers and the write log.
  task automatic monitor_step();
    logic [N-1:0] e_ready, e_grant;
    logic         e_wr, e_busy, bt;
    logic [W-1:0] e_data, d;
    int           e_idx, g, c, k;
    bit           found;

    e_ready = '0; e_grant = '0; e_wr = 1'b0; e_busy = 1'b0; e_data = '0;
    e_idx   = m_shown;

    if (!rst_n) begin
      m_owner = -1; m_beats = 0; m_last = N - 1; m_shown = 0; e_idx = 0;
    end else if (m_owner < 0) begin
      // IDLE: nothing visible; choose the next owner round-robin.
      found = 1'b0;
      for (int i = 1; i <= N; i++) begin
        c = (m_last + i) % N;
        if (!found && req_valid[c]) begin
          found = 1'b1; m_owner = c; m_shown = c; m_beats = 0;
        end
      end
    end else begin
      g          = m_owner;
      e_busy     = 1'b1;
      e_grant[g] = 1'b1;
      e_ready[g] = !fifo_full;
      bt         = req_valid[g] && !fifo_full;
      e_wr       = bt;
      if (bt) e_data = req_data[g*W +: W];
      e_idx      = g;
      if (bt) m_beats++;
      if (!req_valid[g] || m_beats == MB) begin
        m_last = g; m_owner = -1; m_beats = 0;
      end
    end

    check("wr_en", 32'(wr_en), 32'(e_wr));
    check("wdata", 32'(wdata), 32'(e_data));
    check("ready", 32'(req_ready), 32'(e_ready));
    check("grant", 32'(grant), 32'(e_grant));
    check("grant_idx", 32'(gidx), 32'(e_idx));
    check("busy", 32'(busy), 32'(e_busy));
    check("wr_while_full", 32'(wr_en & fifo_full), 32'd0);
    check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);

    if (rst_n) begin
      if (wr_en) begin
        wlog.push_back('{cyc, wdata});
        if (sb_en) fifo_q.push_back(wdata);
      end
      if (!freeze)
        for (int i = 0; i < N; i++) if (req_ready[i] && req_valid[i]) seq[i]++;
    end

    if (sb_en && fifo_q.size() > 0 && ($urandom_range(99) < pop_pct)) begin
      d = fifo_q.pop_front();
      k = int'(d[7:4]) - 10;
      if (k >= 0 && k < N) begin
        check("sb_order", 32'(d), 32'(base(k) + W'(pop_seq[k] % 16)));
        pop_seq[k]++;
      end else begin
        check("sb_source", 32'(d[7:4]), 32'hA);
      end
    end
    cyc++;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         rst;
    logic [N-1:0] v;
    logic         ff;
    logic         wr;
    logic [W-1:0] d;
    logic [N-1:0] rdy;
    logic [N-1:0] gnt;
    logic [IW-1:0] idx;
    logic         bsy;
  } vec_t;

  vec_t tbl[20];

  logic [W-1:0] exp_rr[12];
  logic [N-1:0] v;
  logic         ff, r;
  int           stall;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; fifo_full = 1'b0;
    for (int k = 0; k < N; k++) begin seq[k] = 0; pop_seq[k] = 0; end
    m_owner = -1; m_beats = 0; m_last = N - 1; m_shown = 0;

    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    //           rst  valid    ff  | wr  data   ready    grant    idx  busy
    tbl[0]  = '{1'b0, 4'b1111, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 4'b1111, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[2]  = '{1'b1, 4'b1111, 1'b0, 1'b1, 8'hA0, 4'b0001, 4'b0001, 2'd0, 1'b1};
    tbl[3]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0001, 2'd0, 1'b1};
    tbl[4]  = '{1'b1, 4'b1111, 1'b0, 1'b1, 8'hA0, 4'b0001, 4'b0001, 2'd0, 1'b1};
    tbl[5]  = '{1'b1, 4'b1111, 1'b0, 1'b1, 8'hA0, 4'b0001, 4'b0001, 2'd0, 1'b1};
    tbl[6]  = '{1'b1, 4'b1111, 1'b0, 1'b1, 8'hA0, 4'b0001, 4'b0001, 2'd0, 1'b1};
    tbl[7]  = '{1'b1, 4'b1111, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[8]  = '{1'b1, 4'b1111, 1'b0, 1'b1, 8'hB0, 4'b0010, 4'b0010, 2'd1, 1'b1};
    tbl[9]  = '{1'b1, 4'b1101, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0010, 2'd1, 1'b1};
    tbl[10] = '{1'b1, 4'b1101, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, 2'd1, 1'b0};
    tbl[11] = '{1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0100, 4'b0100, 2'd2, 1'b1};
    tbl[12] = '{1'b1, 4'b1001, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, 2'd2, 1'b0};
    tbl[13] = '{1'b1, 4'b1001, 1'b0, 1'b1, 8'hD0, 4'b1000, 4'b1000, 2'd3, 1'b1};
    tbl[14] = '{1'b1, 4'b0001, 1'b0, 1'b0, 8'h00, 4'b1000, 4'b1000, 2'd3, 1'b1};
    tbl[15] = '{1'b1, 4'b0001, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, 2'd3, 1'b0};
    tbl[16] = '{1'b1, 4'b0001, 1'b0, 1'b1, 8'hA0, 4'b0001, 4'b0001, 2'd0, 1'b1};
    tbl[17] = '{1'b0, 4'b0001, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[18] = '{1'b1, 4'b0001, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[19] = '{1'b1, 4'b0001, 1'b0, 1'b1, 8'hA0, 4'b0001, 4'b0001, 2'd0, 1'b1};

    exp_rr = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hC0, 8'hC1, 8'hC2, 8'hC3,
               8'hA4, 8'hA5, 8'hA6, 8'hA7};

    // ---- table: reset, bursts, full stall, early release, mid-burst reset
    freeze = 1'b1; sb_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].ff);
      @(negedge clk); #1;
      check($sformatf("tbl%0d_wr", i),   32'(wr_en),     32'(tbl[i].wr));
      check($sformatf("tbl%0d_data", i), 32'(wdata),     32'(tbl[i].d));
      check($sformatf("tbl%0d_rdy", i),  32'(req_ready), 32'(tbl[i].rdy));
      check($sformatf("tbl%0d_gnt", i),  32'(grant),     32'(tbl[i].gnt));
      check($sformatf("tbl%0d_idx", i),  32'(gidx),      32'(tbl[i].idx));
      check($sformatf("tbl%0d_busy", i), 32'(busy),      32'(tbl[i].bsy));
    end
    freeze = 1'b0; sb_en = 1'b1; pop_pct = 100;

    // ---- round robin between req0 and req2
    do_reset();
    for (int i = 0; i < 18; i++) drive(1'b1, 4'b0101, 1'b0);
    @(negedge clk); #1;
    check("rr_count_ok", 32'(wlog.size() >= 12), 32'd1);
    if (wlog.size() >= 12) begin
      for (int i = 0; i < 12; i++) check($sformatf("rr_data%0d", i), 32'(wlog[i].d), 32'(exp_rr[i]));
      check("rr_gap1", 32'(wlog[4].cyc - wlog[3].cyc), 32'd2);
      check("rr_gap2", 32'(wlog[8].cyc - wlog[7].cyc), 32'd2);
    end

    // ---- full stall for 3 cycles after beat 2 of req1
    do_reset();
    stall = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (rst_n && (fifo_full === 1'b1) && stall > 0) begin
        check("stall_wr", 32'(wr_en), 32'd0);
        check("stall_ready", 32'(req_ready), 32'd0);
      end
      ff = (seq[1] == 2) && (stall < 3);
      if (ff) stall++;
      drive(1'b1, (seq[1] < 4) ? 4'b0010 : 4'b0000, ff);
    end
    @(negedge clk); #1;
    check("stall_count", 32'(wlog.size()), 32'd4);
    if (wlog.size() == 4) begin
      for (int i = 0; i < 4; i++) check($sformatf("stall_data%0d", i), 32'(wlog[i].d), 32'(8'hB0 + i));
      check("stall_gap", 32'(wlog[2].cyc - wlog[1].cyc), 32'd4);
    end

    // ---- early release: req3 drops after 2 beats, req0 takes over
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      v    = '0;
      v[3] = (seq[3] < 2);
      v[0] = (seq[3] >= 1);
      drive(1'b1, v, 1'b0);
    end
    @(negedge clk); #1;
    check("early_count_ok", 32'(wlog.size() >= 3), 32'd1);
    if (wlog.size() >= 3) begin
      check("early_d0", 32'(wlog[0].d), 32'hD0);
      check("early_d1", 32'(wlog[1].d), 32'hD1);
      check("early_d2", 32'(wlog[2].d), 32'hA0);
      check("early_gap", 32'(wlog[2].cyc - wlog[1].cyc), 32'd3);
    end

    // ---- single requester: 4-beat bursts separated by one idle cycle
    do_reset();
    for (int i = 0; i < 20; i++) drive(1'b1, 4'b0010, 1'b0);
    @(negedge clk); #1;
    check("single_count", 32'(wlog.size()), 32'd16);
    if (wlog.size() == 16) begin
      for (int i = 0; i < 16; i++) check($sformatf("single_d%0d", i), 32'(wlog[i].d), 32'(8'hB0 + i));
      for (int i = 1; i < 16; i++)
        check($sformatf("single_gap%0d", i), 32'(wlog[i].cyc - wlog[i-1].cyc), (i % 4 == 0) ? 32'd2 : 32'd1);
    end

    // ---- random traffic against the model and scoreboard
    do_reset();
    pop_pct = 50;
    v = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < N; k++) if ($urandom_range(7) == 0) v[k] = ~v[k];
      ff = ($urandom_range(9) == 0);
      r  = ($urandom_range(199) != 0);
      drive(r, v, ff);
    end
    @(negedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
